// File: rtl/ai_seq.sv
// ai_seq: batch sequencer that loads host samples into input memory, then streams addresses through a LAT-cycle array into output memory
module ai_seq #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 2,
    parameter int LAT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic                  wr,
    output logic [7:0]            addr_i,
    output logic [N_IN*WIDTH-1:0] i,
    output logic                  o_wr,
    output logic [7:0]            addr_o,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] n_q, n_d, cnt_q, cnt_d, addr_i_q, addr_i_d;
    logic wr_q, wr_d, issue_q, issue_d, done_q, done_d;
    logic [N_IN*WIDTH-1:0] i_q, i_d;
    logic [LAT-1:0] v_q;
    logic [LAT-1:0][7:0] a_q;
    logic last;

    assign last     = cnt_q == n_q - 8'd1;
    assign in_ready = state_q == LOAD;
    assign busy     = state_q inside {LOAD, RUN, DRAIN};
    assign wr       = wr_q;
    assign addr_i   = addr_i_q;
    assign i        = i_q;
    assign done     = done_q;
    assign o_wr     = v_q[LAT-1];
    assign addr_o   = a_q[LAT-1];

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        addr_i_d = addr_i_q;
        i_d      = i_q;
        wr_d     = 1'b0;
        issue_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (n == 8'd0) done_d = 1'b1;
                else begin
                    n_d     = n;
                    cnt_d   = 8'd0;
                    state_d = LOAD;
                end
            end
            LOAD: if (in_valid) begin
                wr_d     = 1'b1;
                addr_i_d = cnt_q;
                i_d      = in_data;
                cnt_d    = last ? 8'd0 : cnt_q + 8'd1;
                state_d  = last ? RUN : LOAD;
            end
            RUN: begin
                // counter parks on n-1 so addr_i holds the last address through DRAIN
                issue_d  = 1'b1;
                addr_i_d = cnt_q;
                cnt_d    = last ? cnt_q : cnt_q + 8'd1;
                state_d  = last ? DRAIN : RUN;
            end
            DRAIN: if (o_wr && addr_o == n_q - 8'd1) begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            addr_i_q <= '0;
            i_q      <= '0;
            wr_q     <= 1'b0;
            issue_q  <= 1'b0;
            done_q   <= 1'b0;
            v_q      <= '0;
            a_q      <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            addr_i_q <= addr_i_d;
            i_q      <= i_d;
            wr_q     <= wr_d;
            issue_q  <= issue_d;
            done_q   <= done_d;
            v_q[0]   <= issue_q;
            a_q[0]   <= addr_i_q;
            for (int j = 1; j < LAT; j++) begin
                v_q[j] <= v_q[j-1];
                a_q[j] <= a_q[j-1];
            end
        end
    end
endmodule

// File: tb/tb_ai_seq.sv
// tb_ai_seq: directed scoreboard bench for ai_seq with default parameters
module tb_ai_seq;
    localparam int DW = 64;
    typedef struct packed {
        logic       w;
        logic [7:0] ai;
        logic       ow;
        logic [7:0] ao;
        logic       d;
        logic       b;
        logic       r;
    } row_t;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, wr, o_wr, busy, done;
    logic [7:0] n, addr_i, addr_o;
    logic [DW-1:0] in_data, i;
    int vectors = 0, miscompares = 0;
    int wr_cnt = 0, owr_cnt = 0, done_cnt = 0;
    int w0, o0, d0, k;
    logic [7:0] max_ai = 8'd0;
    logic [71:0] e;
    logic [71:0] wr_exp[$];
    logic [7:0] o_exp[$];
    logic [DW-1:0] dat [3] = '{64'hA0A0_0001_A0A0_0002, 64'hB0B0_0003_B0B0_0004, 64'hC0C0_0005_C0C0_0006};
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    row_t tbl [12] = '{
        '{1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1},
        '{1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1},
        '{1'b1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1},
        '{1'b1, 8'd2, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'd1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'd2, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'd2, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'd2, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'd2, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0},
        '{1'b0, 8'd2, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0},
        '{1'b0, 8'd2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0}
    };

    ai_seq dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr(wr), .addr_i(addr_i), .i(i), .o_wr(o_wr), .addr_o(addr_o),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (done !== 1'b1 && c < 400) begin
            step();
            c++;
        end
        chk(tag, done, 1);
    endtask

    task automatic snap();
        w0 = wr_cnt;
        o0 = owr_cnt;
        d0 = done_cnt;
    endtask

    task automatic load(input int cnt);
        for (int j = 0; j < cnt; j++) begin
            o_exp.push_back(8'(j));
        end
        start = 1'b1;
        n = 8'(cnt);
        step();
        start = 1'b0;
        for (int j = 0; j < cnt; j++) begin
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            wr_exp.push_back({8'(j), in_data});
            step();
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (addr_i > max_ai) max_ai = addr_i;
        if (done === 1'b1) done_cnt++;
        if (wr === 1'b1) begin
            wr_cnt++;
            if (wr_exp.size() == 0) chk("wr_extra", wr, 0);
            else begin
                e = wr_exp.pop_front();
                chk("wr_addr", addr_i, e[71:64]);
                chk("wr_data", i, e[63:0]);
            end
        end
        if (o_wr === 1'b1) begin
            owr_cnt++;
            if (o_exp.size() == 0) chk("owr_extra", o_wr, 0);
            else chk("owr_addr", addr_o, o_exp.pop_front());
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; n = 8'd0; in_valid = 1'b0; in_data = '0;
        step();
        step();
        chk("rst_wr", wr, 0);
        chk("rst_addr_i", addr_i, 0);
        chk("rst_i", i, 0);
        chk("rst_o_wr", o_wr, 0);
        chk("rst_addr_o", addr_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        // n=3 with in_valid held high: cycle-exact trace
        for (int r = 0; r < 12; r++) begin
            start = (r == 0);
            n = 8'd3;
            in_valid = (r >= 1);
            in_data = (r >= 1 && r <= 3) ? dat[r-1] : 64'hDEAD_BEEF_0000_0000 + 64'(r);
            if (r == 0) for (int j = 0; j < 3; j++) o_exp.push_back(8'(j));
            if (r >= 1 && r <= 3) wr_exp.push_back({8'(r-1), in_data});
            step();
            chk($sformatf("s1_wr_%0d", r), wr, tbl[r].w);
            chk($sformatf("s1_addr_i_%0d", r), addr_i, tbl[r].ai);
            chk($sformatf("s1_o_wr_%0d", r), o_wr, tbl[r].ow);
            if (tbl[r].ow) chk($sformatf("s1_addr_o_%0d", r), addr_o, tbl[r].ao);
            chk($sformatf("s1_done_%0d", r), done, tbl[r].d);
            chk($sformatf("s1_busy_%0d", r), busy, tbl[r].b);
            chk($sformatf("s1_in_ready_%0d", r), in_ready, tbl[r].r);
        end
        in_valid = 1'b0;
        // n=2 with a two-cycle valid gap
        snap();
        o_exp.push_back(8'd0);
        o_exp.push_back(8'd1);
        start = 1'b1; n = 8'd2;
        step();
        start = 1'b0;
        k = 0;
        for (int p = 0; p < 4; p++) begin
            in_valid = pat[p];
            in_data = {$urandom, $urandom};
            if (pat[p]) begin
                wr_exp.push_back({8'(k), in_data});
                k++;
            end
            step();
            chk($sformatf("s2_wr_%0d", p), wr, pat[p]);
        end
        in_valid = 1'b0;
        wait_done("s2_done");
        step();
        step();
        chk("s2_wr_cnt", wr_cnt - w0, 2);
        chk("s2_owr_cnt", owr_cnt - o0, 2);
        // n=0 completes immediately
        snap();
        start = 1'b1; n = 8'd0;
        step();
        start = 1'b0;
        chk("s3_done", done, 1);
        chk("s3_busy", busy, 0);
        chk("s3_in_ready", in_ready, 0);
        step();
        chk("s3_done_low", done, 0);
        chk("s3_busy_low", busy, 0);
        step();
        chk("s3_wr_cnt", wr_cnt - w0, 0);
        chk("s3_owr_cnt", owr_cnt - o0, 0);
        chk("s3_done_cnt", done_cnt - d0, 1);
        // start re-pulsed during RUN must be ignored
        snap();
        load(5);
        step();
        chk("s4_busy_run", busy, 1);
        start = 1'b1; n = 8'd7;
        step();
        step();
        start = 1'b0;
        wait_done("s4_done");
        step();
        step();
        chk("s4_owr_cnt", owr_cnt - o0, 5);
        chk("s4_done_cnt", done_cnt - d0, 1);
        chk("s4_busy_idle", busy, 0);
        chk("s4_oq_empty", o_exp.size(), 0);
        // reset during DRAIN aborts the batch
        snap();
        load(4);
        repeat (5) step();
        chk("s5_busy_drain", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        o_exp.delete();
        chk("s5_wr", wr, 0);
        chk("s5_addr_i", addr_i, 0);
        chk("s5_i", i, 0);
        chk("s5_o_wr", o_wr, 0);
        chk("s5_addr_o", addr_o, 0);
        chk("s5_busy", busy, 0);
        chk("s5_done", done, 0);
        chk("s5_in_ready", in_ready, 0);
        chk("s5_owr_before", owr_cnt - o0, 2);
        repeat (10) step();
        chk("s5_owr_after", owr_cnt - o0, 2);
        chk("s5_no_done", done_cnt - d0, 0);
        snap();
        load(1);
        wait_done("s5_n1_done");
        step();
        step();
        chk("s5_n1_owr", owr_cnt - o0, 1);
        chk("s5_n1_done_cnt", done_cnt - d0, 1);
        // n=255 reaches 254 with no wrap
        snap();
        max_ai = 8'd0;
        load(255);
        wait_done("s6_done");
        step();
        step();
        chk("s6_max_addr_i", max_ai, 254);
        chk("s6_wr_cnt", wr_cnt - w0, 255);
        chk("s6_owr_cnt", owr_cnt - o0, 255);
        chk("s6_done_cnt", done_cnt - d0, 1);
        chk("wr_q_empty", wr_exp.size(), 0);
        chk("o_q_empty", o_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
